// File: rtl/multi_pkg.sv
// Shared constants, state type and ROM contents
// for the 8x8 matrix-multiply engine.
package multi_pkg;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_multi_state;

  // X[a] = a, row-major
  function automatic logic [DW-1:0] x_init(
    input logic [AW-1:0] a
  );
    return DW'(a);
  endfunction

  // Y[a] = a, row-major
  function automatic logic [DW-1:0] y_init(
    input logic [AW-1:0] a
  );
    return DW'(a);
  endfunction

endpackage

// File: rtl/multi_ram.sv
// 64x32 simple dual-port RAM, registered read,
// write-through on same-address collision.
module multi_ram
  import multi_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [N*N];
  logic [DW-1:0] r_rdata;

  // Write port plus registered read; a write to the
  // address being read is forwarded so it is visible
  // on the very next cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/multi_top.sv
// Z = X * Y engine: one MAC per cycle, k innermost,
// two-stage pipe (ROM read, multiply-accumulate).
module multi_top
  import multi_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  input  logic [AW-1:0] z_rd_addr,
  output logic [DW-1:0] z_dout
);

  t_multi_state r_state;
  t_multi_state w_next;

  logic          r_start_q;
  logic          w_edge;
  logic          w_launch;

  logic [2:0]    r_i;
  logic [2:0]    r_j;
  logic [2:0]    r_k;
  logic          r_drain;
  logic          w_issue;

  logic [DW-1:0] r_xd;
  logic [DW-1:0] r_yd;
  logic          r_s1_v;
  logic          r_s1_last;
  logic [AW-1:0] r_s1_waddr;

  logic [DW-1:0] r_acc;
  logic [DW-1:0] w_prod;
  logic [DW-1:0] w_sum;
  logic          w_we;
  logic          w_last_wr;

  assign w_edge    = start & ~r_start_q;
  assign w_issue   = (r_state == RUN) & ~r_drain;
  assign w_prod    = r_xd * r_yd;
  assign w_sum     = r_acc + w_prod;
  assign w_we      = r_s1_v & r_s1_last;
  assign w_last_wr = w_we & (r_s1_waddr == AW'(N*N-1));
  assign done      = (r_state == DONE);

  // Start edge detector, tracks start in every state
  always_ff @(posedge clk) begin
    if (reset) r_start_q <= 1'b0;
    else       r_start_q <= start;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; edges are only honoured outside RUN
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_next   = RUN;
          w_launch = 1'b1;
        end
      end
      RUN: begin
        if (w_last_wr) w_next = DONE;
      end
      DONE: begin
        if (w_edge) begin
          w_next   = RUN;
          w_launch = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // i/j/k loop counters; drain flag stops issue
  // after the final (7,7,7) term is sent down the pipe
  always_ff @(posedge clk) begin
    if (reset || w_launch) begin
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_drain <= 1'b0;
    end else if (w_issue) begin
      r_k <= r_k + 3'd1;
      if (r_k == 3'd7) begin
        r_j <= r_j + 3'd1;
        if (r_j == 3'd7) begin
          r_i <= r_i + 3'd1;
          if (r_i == 3'd7) r_drain <= 1'b1;
        end
      end
    end
  end

  // X and Y ROMs, synchronous read
  always_ff @(posedge clk) begin
    r_xd <= x_init({r_i, r_k});
    r_yd <= y_init({r_k, r_j});
  end

  // Stage-1 control travelling with the ROM data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v     <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_waddr <= '0;
    end else begin
      r_s1_v     <= w_issue;
      r_s1_last  <= (r_k == 3'd7);
      r_s1_waddr <= {r_i, r_j};
    end
  end

  // Accumulator, cleared after each element write
  always_ff @(posedge clk) begin
    if (reset || w_launch) begin
      r_acc <= '0;
    end else if (r_s1_v) begin
      r_acc <= r_s1_last ? '0 : w_sum;
    end
  end

  multi_ram u_zram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_s1_waddr),
    .i_wdata (w_sum),
    .i_raddr (z_rd_addr),
    .o_rdata (z_dout)
  );

endmodule

// File: tb/tb_multi_top.sv
// Bench for multi_top: reference Z from the
// matrix definition, randomized read order/gaps.
module tb_multi_top;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic [5:0]  z_rd_addr;
  logic [31:0] z_dout;

  int checks;
  int failures;
  int ref_lat;
  logic [31:0] z_ref [64];

  multi_top dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .z_rd_addr (z_rd_addr),
    .z_dout    (z_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void build_ref();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        logic [31:0] s;
        logic [31:0] xv;
        logic [31:0] yv;
        s = 0;
        for (int k = 0; k < 8; k++) begin
          xv = 32'(i * 8 + k);
          yv = 32'(k * 8 + j);
          s  = s + xv * yv;
        end
        z_ref[i*8+j] = s;
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    @(negedge clk);
    z_rd_addr = 6'(a);
    @(negedge clk);
    v = z_dout;
  endtask

  // Raise start so the next posedge samples an edge
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Cycles from the edge-sampling cycle until done=1;
  // d1 is done in the cycle right after that edge.
  task automatic wait_done(
    input  bit   hold,
    output int   lat,
    output bit   ok,
    output logic d1
  );
    lat = 0;
    ok  = 1'b0;
    d1  = 1'bx;
    repeat (2000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        d1 = done;
        if (!hold) start = 1'b0;
      end
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    z_rd_addr = '0;
    idle(3);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_latency();
    int l1, l2;
    bit ok1, ok2;
    logic d1;
    int drop;
    idle($urandom_range(1, 20));
    launch();
    wait_done(1'b0, l1, ok1, d1);
    checks++;
    if (!ok1 || l1 < 514 || l1 > 530) begin
      failures++;
      $display("FAIL lat_run1 got=%0d ok=%b exp=514..530",
               l1, ok1);
    end
    drop = 0;
    repeat (100) begin
      @(negedge clk);
      if (done !== 1'b1) drop++;
    end
    checks++;
    if (drop != 0) begin
      failures++;
      $display("FAIL done_sticky drops=%0d exp=0", drop);
    end
    idle($urandom_range(1, 30));
    launch();
    wait_done(1'b0, l2, ok2, d1);
    checks++;
    if (d1 !== 1'b0) begin
      failures++;
      $display("FAIL done_fall got=%b exp=0", d1);
    end
    checks++;
    if (!ok2 || l2 != l1) begin
      failures++;
      $display("FAIL lat_repeat got=%0d exp=%0d", l2, l1);
    end
    ref_lat = l1;
  endtask

  task automatic test_z_all();
    int order [64];
    int bad;
    logic [31:0] v;
    for (int a = 0; a < 64; a++) order[a] = a;
    for (int a = 63; a > 0; a--) begin
      int r, t;
      r = $urandom_range(0, a);
      t = order[a];
      order[a] = order[r];
      order[r] = t;
    end
    bad = 0;
    for (int n = 0; n < 64; n++) begin
      rd(order[n], v);
      checks++;
      if (v !== z_ref[order[n]]) begin
        failures++;
        bad++;
        if (bad < 8)
          $display("FAIL z_all[%0d] got=%0d exp=%0d",
                   order[n], v, z_ref[order[n]]);
      end
    end
    rd(0, v);
    checks++;
    if (v !== 32'd1120) begin
      failures++;
      $display("FAIL z0 got=%0d exp=1120", v);
    end
    rd(1, v);
    checks++;
    if (v !== 32'd1148) begin
      failures++;
      $display("FAIL z1 got=%0d exp=1148", v);
    end
    rd(8, v);
    checks++;
    if (v !== 32'd2912) begin
      failures++;
      $display("FAIL z8 got=%0d exp=2912", v);
    end
    rd(63, v);
    checks++;
    if (v !== 32'd16996) begin
      failures++;
      $display("FAIL z63 got=%0d exp=16996", v);
    end
  endtask

  task automatic test_hold_start();
    int l, drop;
    bit ok;
    logic d1;
    logic [31:0] v;
    idle(5);
    launch();
    wait_done(1'b1, l, ok, d1);
    checks++;
    if (!ok || l != ref_lat) begin
      failures++;
      $display("FAIL hold_lat got=%0d exp=%0d", l, ref_lat);
    end
    drop = 0;
    repeat (700) begin
      @(negedge clk);
      if (done !== 1'b1) drop++;
    end
    checks++;
    if (drop != 0) begin
      failures++;
      $display("FAIL hold_rerun drops=%0d exp=0", drop);
    end
    start = 1'b0;
    rd($urandom_range(0, 63), v);
    checks++;
    if (v !== z_ref[z_rd_addr]) begin
      failures++;
      $display("FAIL hold_z got=%0d exp=%0d",
               v, z_ref[z_rd_addr]);
    end
  endtask

  task automatic test_ignore_edge();
    int lat;
    bit ok;
    idle(4);
    launch();
    lat = 0;
    ok = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      lat++;
      if (lat == 98)  start = 1'b0;
      if (lat == 100) start = 1'b1;
      if (lat == 102) start = 1'b0;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || lat != ref_lat) begin
      failures++;
      $display("FAIL ignore_edge got=%0d exp=%0d",
               lat, ref_lat);
    end
  endtask

  task automatic test_reset_midrun();
    int l, rise;
    bit ok;
    logic d1;
    logic [31:0] v;
    idle(3);
    launch();
    @(negedge clk);
    start = 1'b0;
    idle(199);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_done got=%b exp=0", done);
    end
    rise = 0;
    repeat (600) begin
      @(negedge clk);
      if (done !== 1'b0) rise++;
    end
    checks++;
    if (rise != 0) begin
      failures++;
      $display("FAIL rst_mid_idle rises=%0d exp=0", rise);
    end
    launch();
    wait_done(1'b0, l, ok, d1);
    checks++;
    if (!ok || l != ref_lat) begin
      failures++;
      $display("FAIL rst_mid_lat got=%0d exp=%0d", l, ref_lat);
    end
    rd(63, v);
    checks++;
    if (v !== 32'd16996) begin
      failures++;
      $display("FAIL rst_mid_z63 got=%0d exp=16996", v);
    end
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    z_rd_addr = 6'd4;
    @(negedge clk);
    z_rd_addr = 6'd5;
    checks++;
    if (z_dout !== z_ref[4]) begin
      failures++;
      $display("FAIL rdlat_4 got=%0d exp=%0d", z_dout, z_ref[4]);
    end
    @(negedge clk);
    z_rd_addr = 6'd6;
    checks++;
    if (z_dout !== z_ref[5]) begin
      failures++;
      $display("FAIL rdlat_5 got=%0d exp=%0d", z_dout, z_ref[5]);
    end
    @(negedge clk);
    checks++;
    if (z_dout !== z_ref[6]) begin
      failures++;
      $display("FAIL rdlat_6 got=%0d exp=%0d", z_dout, z_ref[6]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ref_lat  = 514;
    build_ref();
    test_reset();
    test_latency();
    test_z_all();
    test_hold_start();
    test_ignore_edge();
    test_reset_midrun();
    test_read_latency();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
